// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: status bit map,
// frame width and transmit FSM states.
package uart_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  localparam int unsigned TX_ST_BUSY = 0;
  localparam int unsigned TX_ST_FULL = 1;
  localparam int unsigned TX_ST_OVF  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with first-word-fall-through output; pointers wrap
// naturally and the occupancy count is one bit wider than the pointers.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = UART_DATA_BITS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  // Guard against misuse: never write past full or read past empty.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: IO stores to the data register queue bytes
// that are serialized as back-to-back 8N1 frames on a registered tx line.
module uart_tx_io
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 200,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        UARTCtrl,
  input  logic        ioWrite,
  input  logic [7:0]  write_data,
  output logic [31:0] tx_status,
  output logic        tx
);

  localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_e                 state_q, state_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_cnt_q, bit_cnt_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      ovf_q, ovf_d;

  logic                      wr_req;
  logic                      fifo_push;
  logic                      fifo_pop;
  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [FCNT_W-1:0]         fifo_count;
  logic                      bit_done;
  logic                      busy;

  // Full comes from the registered count, so a write while full is dropped
  // even when a pop lands in the same cycle.
  assign wr_req    = ioWrite & UARTCtrl;
  assign fifo_push = wr_req & ~fifo_full;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (write_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign bit_done = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    fifo_pop  = 1'b0;
    ovf_d     = ovf_q | (wr_req & fifo_full);

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          shift_d   = fifo_dout;
          bit_cnt_d = '0;
          clk_cnt_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 3'(1);
          if (bit_cnt_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_dout;
            bit_cnt_d = '0;
            state_d   = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Line level follows the state being entered so tx stays aligned with it.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy = (fifo_count != '0) | (state_q != ST_IDLE);
  assign tx   = tx_q;

  always_comb begin
    tx_status             = '0;
    tx_status[TX_ST_BUSY] = busy;
    tx_status[TX_ST_FULL] = fifo_full;
    tx_status[TX_ST_OVF]  = ovf_q;
  end

endmodule

// File: tb/tb_uart_tx_io.sv
// Scoreboard bench for uart_tx_io: stimulus queues expected bytes, a line
// monitor decodes 8N1 frames from tx and compares them against the queue.
module tb_uart_tx_io;

  localparam int unsigned CPB = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        UARTCtrl;
  logic        ioWrite;
  logic [7:0]  write_data;
  logic [31:0] tx_status;
  logic        tx;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  bit          rst_seen = 1'b0;
  logic [7:0]  exp_q[$];
  int          start_q[$];

  uart_tx_io #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .UARTCtrl   (UARTCtrl),
    .ioWrite    (ioWrite),
    .write_data (write_data),
    .tx_status  (tx_status),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc++;
    if (rst) rst_seen = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line monitor: hunt for a start bit, sample each bit mid-period.
  initial begin : monitor
    logic [7:0] got;
    logic [7:0] want;
    bit         ab;
    forever begin
      @(negedge clk);
      if (!rst && tx == 1'b0) begin
        start_q.push_back(cyc);
        rst_seen = 1'b0;
        ab       = 1'b0;
        got      = '0;
        for (int i = 0; i < 8; i++) begin
          repeat ((i == 0) ? 6 : 4) @(negedge clk);
          if (rst_seen) begin
            ab = 1'b1;
            break;
          end
          got[i] = tx;
        end
        if (!ab) begin
          repeat (4) @(negedge clk);
          if (!rst_seen) begin
            check("stop_bit", 32'(tx), 32'd1);
            if (exp_q.size() == 0) begin
              check("unexpected_frame", 32'(got), 32'hFFFF_FFFF);
            end else begin
              want = exp_q.pop_front();
              check("frame_byte", 32'(got), 32'(want));
            end
          end
        end
      end
    end
  end

  task automatic set_bus(input logic ctl, input logic wr, input logic [7:0] d);
    UARTCtrl   = ctl;
    ioWrite    = wr;
    write_data = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    set_bus(1'b0, 1'b0, 8'h00);
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("reset_status", tx_status, 32'h0);
    check("reset_tx", 32'(tx), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    start_q.delete();
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (tx_status[0] == 1'b0) break;
      @(negedge clk);
    end
    check("idle_reached", 32'(tx_status[0]), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin : stim
    logic [7:0] b;
    logic       exp_tx;
    int         busy_cnt;

    rst = 1'b1;
    set_bus(1'b0, 1'b0, 8'h00);
    @(negedge clk);
    do_reset();

    // Single byte 0x55: k counts cycles after the accepting edge.
    b = 8'h55;
    set_bus(1'b1, 1'b1, b);
    exp_q.push_back(b);
    @(negedge clk);
    set_bus(1'b0, 1'b0, 8'h00);
    check("single_status_k0", tx_status, 32'h1);
    for (int k = 0; k <= 44; k++) begin
      if (k == 0)       exp_tx = 1'b1;
      else if (k <= 4)  exp_tx = 1'b0;
      else if (k <= 36) exp_tx = b[(k - 5) / 4];
      else              exp_tx = 1'b1;
      check($sformatf("single_tx_k%0d", k), 32'(tx), 32'(exp_tx));
      if (k == 40 || k == 41)
        check($sformatf("single_busy_k%0d", k), 32'(tx_status[0]), (k <= 40) ? 32'd1 : 32'd0);
      @(negedge clk);
    end

    // Back-to-back 0xA3, 0x0F.
    start_q.delete();
    busy_cnt = 0;
    set_bus(1'b1, 1'b1, 8'hA3);
    exp_q.push_back(8'hA3);
    @(negedge clk);
    if (tx_status[0]) busy_cnt++;
    set_bus(1'b1, 1'b1, 8'h0F);
    exp_q.push_back(8'h0F);
    @(negedge clk);
    set_bus(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 200; i++) begin
      if (!tx_status[0]) break;
      busy_cnt++;
      @(negedge clk);
    end
    check("b2b_busy_cycles", 32'(busy_cnt), 32'd81);
    repeat (2) @(negedge clk);
    check("b2b_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2)
      check("b2b_start_gap", 32'(start_q[1] - start_q[0]), 32'd40);

    // Overflow: ten writes, ninth fills the queue, tenth is dropped.
    for (int i = 0; i < 10; i++) begin
      set_bus(1'b1, 1'b1, 8'(i));
      if (i < 9) exp_q.push_back(8'(i));
      @(negedge clk);
      if (i == 7) check("ovf_status_k7", tx_status, 32'h1);
      if (i == 8) check("ovf_status_k8", tx_status, 32'h3);
      if (i == 9) check("ovf_status_k9", tx_status, 32'h7);
    end
    set_bus(1'b0, 1'b0, 8'h00);
    wait_idle(600);
    check("ovf_sticky_after_drain", tx_status, 32'h4);

    // Write while full coinciding with the pop at the end of the first frame.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      set_bus(1'b1, 1'b1, 8'(8'h10 + i));
      exp_q.push_back(8'(8'h10 + i));
      @(negedge clk);
    end
    set_bus(1'b0, 1'b0, 8'h00);
    check("pp_full_k8", tx_status, 32'h3);
    repeat (32) @(negedge clk);
    check("pp_full_k40", tx_status, 32'h3);
    set_bus(1'b1, 1'b1, 8'h99);
    @(negedge clk);
    check("pp_drop_k41", tx_status, 32'h5);
    set_bus(1'b1, 1'b1, 8'h1A);
    exp_q.push_back(8'h1A);
    @(negedge clk);
    check("pp_refill_k42", tx_status, 32'h7);
    set_bus(1'b0, 1'b0, 8'h00);
    wait_idle(700);
    check("pp_sticky_after_drain", tx_status, 32'h4);

    // Reset during DATA bit 3 with three bytes queued.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_bus(1'b1, 1'b1, 8'(8'h21 + i));
      exp_q.push_back(8'(8'h21 + i));
      @(negedge clk);
    end
    set_bus(1'b0, 1'b0, 8'h00);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_tx", 32'(tx), 32'd1);
    check("midrst_status", tx_status, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_discard_status", tx_status, 32'h0);
    check("midrst_discard_tx", 32'(tx), 32'd1);

    // Decode qualification: neither strobe alone pushes.
    set_bus(1'b0, 1'b1, 8'hEE);
    repeat (2) @(negedge clk);
    set_bus(1'b1, 1'b0, 8'hEE);
    repeat (2) @(negedge clk);
    set_bus(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("qual_status_%0d", i), tx_status, 32'h0);
      check($sformatf("qual_tx_%0d", i), 32'(tx), 32'd1);
      @(negedge clk);
    end

    // Clean frame after mid-frame reset.
    set_bus(1'b1, 1'b1, 8'hC4);
    exp_q.push_back(8'hC4);
    @(negedge clk);
    set_bus(1'b0, 1'b0, 8'h00);
    check("post_rst_status", tx_status, 32'h1);
    wait_idle(200);
    check("post_rst_final_status", tx_status, 32'h0);

    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
